io_hard_bottom_pad_ctrl: RTL

Controller for the bottom-edge hard I/O tile, which has four input pads and one output pad. It shares the single output pad among `N_REQ` fabric-side requesters using round-robin, burst-limited arbitration with a guaranteed idle turnaround cycle. It also synchronises the four input pads into the `clk` domain and produces rising-edge pulses. It sits between the tile's inpad/outpad pins and the fabric logic that uses them.

---
 rtl/io_pad_ctrl_pkg.sv | 22 ++
 rtl/io_pad_sync.sv | 31 +++
 rtl/io_hard_bottom_pad_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/io_pad_ctrl_pkg.sv
// Purpose: shared types and defaults for the bottom-edge hard I/O pad controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_pad_ctrl_pkg;

   // Output-pad ownership phases: free, owned by one requester, one-cycle handover gap.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } pad_state_t;

   localparam int   DEF_BURST_LEN   = 8;
   localparam int   DEF_SYNC_STAGES = 2;
   localparam logic DEF_IDLE_LEVEL  = 1'b0;

   // Burst counter width; a one-cycle burst still needs a one-bit counter.
   function automatic int cnt_width(input int burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

endpackage

// File: rtl/io_pad_sync.sv
// Purpose: one-bit multi-flop synchroniser for an asynchronous pad, with rising-edge pulse.
// Latency: din change before edge e appears on sync SYNC_STAGES edges later; rise in that same cycle.
// Backpressure: none; free-running sampler.
module io_pad_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   sync_prev;

   // Shift the raw pad level through the flop chain; remember the previous synchronised level.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain     <= '0;
         sync_prev <= 1'b0;
      end else begin
         chain     <= {chain[SYNC_STAGES-2:0], din};
         sync_prev <= chain[SYNC_STAGES-1];
      end
   end

   assign sync = chain[SYNC_STAGES-1];
   assign rise = chain[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/io_hard_bottom_pad_ctrl.sv
// Purpose: round-robin, burst-limited sharing of one outpad among N_REQ requesters plus inpad sync.
// Latency: req in IDLE -> gnt/busy next cycle; outpad carries owner data one cycle after sampling.
// Backpressure: requesters hold req until granted; non-owner req is ignored until the pad is IDLE again.
module io_hard_bottom_pad_ctrl
   import io_pad_ctrl_pkg::*;
#(
   parameter int   N_REQ       = 4,
   parameter int   BURST_LEN   = DEF_BURST_LEN,
   parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL,
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         req_data,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic                     outpad,
   input  logic [3:0]               inpad,
   output logic [3:0]               in_sync,
   output logic [3:0]               in_rise
);

   localparam int                OW       = $clog2(N_REQ);
   localparam int                CNT_W    = cnt_width(BURST_LEN);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);

   pad_state_t       state, state_nxt;
   logic [OW-1:0]    rr_ptr, rr_ptr_nxt;
   logic [OW-1:0]    owner_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic             busy_nxt;
   logic             outpad_nxt;
   logic [OW-1:0]    pick;
   logic             pick_vld;

   // Requester index 'off' positions after 'base', wrapping at N_REQ (N_REQ need not be a power of two).
   function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int off);
      return OW'((int'(base) + off) % N_REQ);
   endfunction

   // Round-robin pick: first active requester at or after rr_ptr. Scanning from the far end
   // lets the nearest candidate overwrite the others.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[rr_idx(rr_ptr, i)]) begin
            pick     = rr_idx(rr_ptr, i);
            pick_vld = 1'b1;
         end
      end
   end

   // Next-state and registered-output decode for the ownership FSM.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      cnt_nxt    = cnt;
      gnt_nxt    = gnt;
      busy_nxt   = busy;
      outpad_nxt = outpad;
      unique case (state)
         IDLE: begin
            outpad_nxt = IDLE_LEVEL;
            if (pick_vld) begin
               state_nxt       = GRANT;
               gnt_nxt         = '0;
               gnt_nxt[pick]   = 1'b1;
               owner_nxt       = pick;
               busy_nxt        = 1'b1;
               cnt_nxt         = '0;
               outpad_nxt      = req_data[pick];
            end
         end
         GRANT: begin
            // Release and burst expiry together still yield a single move to TURN.
            if (!req[owner] || (cnt == CNT_LAST)) begin
               state_nxt  = TURN;
               gnt_nxt    = '0;
               busy_nxt   = 1'b0;
               outpad_nxt = IDLE_LEVEL;
            end else begin
               cnt_nxt    = cnt + 1'b1;
               outpad_nxt = req_data[owner];
            end
         end
         TURN: begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            outpad_nxt = IDLE_LEVEL;
         end
         default: begin
            state_nxt  = IDLE;
            gnt_nxt    = '0;
            busy_nxt   = 1'b0;
            outpad_nxt = IDLE_LEVEL;
         end
      endcase
   end

   // State and output registers; reset abandons any burst without a handover cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         cnt    <= '0;
         gnt    <= '0;
         busy   <= 1'b0;
         outpad <= IDLE_LEVEL;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
         cnt    <= cnt_nxt;
         gnt    <= gnt_nxt;
         busy   <= busy_nxt;
         outpad <= outpad_nxt;
      end
   end

   // One synchroniser per input pad.
   for (genvar p = 0; p < 4; p++) begin : g_inpad
      io_pad_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (inpad[p]),
         .sync  (in_sync[p]),
         .rise  (in_rise[p])
      );
   end

endmodule
